// File: rtl/div_pkg.sv
// div_pkg: shared widths, counter size and FSM state type for the sequential divider
// Holds DIV_DATA_WIDTH, DIV_DIVIDEND_WIDTH, DIV_CNT_WIDTH and div_state_e.
package div_pkg;
    localparam int DIV_DATA_WIDTH     = 12;
    localparam int DIV_DIVIDEND_WIDTH = 2 * DIV_DATA_WIDTH;
    localparam int DIV_CNT_WIDTH      = $clog2(DIV_DIVIDEND_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one combinational restoring-division iteration
// Ports: rem_i partial remainder, bit_i next dividend bit (MSB first), divisor_i divisor,
//        rem_o next partial remainder, q_o quotient bit.
module div_restoring_step
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  bit_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  q_o
);
    logic [DATA_WIDTH:0] shifted;
    assign shifted = {rem_i, bit_i};
    assign q_o     = shifted >= {1'b0, divisor_i};
    // the kept value is always below the divisor, so it fits in DATA_WIDTH bits
    assign rem_o   = DATA_WIDTH'(q_o ? shifted - {1'b0, divisor_i} : shifted);
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, one quotient bit per clock
// Ports: clk, rst_n (async active-low); valid_i/ready_o input handshake with dividend_i, divisor_i;
//        valid_o one-cycle strobe with held quotient_o, remainder_o, div_by_zero_o.
// Option: define DIV_ROUND_NEAREST_EN to round the quotient half-up (remainder stays raw).
module seq_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
    parameter int DIVIDEND_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0]     divisor_i,
    output logic                      valid_o,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0]     remainder_o,
    output logic                      div_by_zero_o
);
    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    div_state_e                state_q, state_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_q;
    logic [DATA_WIDTH-1:0]     dsr_q;
    logic [DATA_WIDTH-1:0]     rem_q;
    logic [DATA_WIDTH-1:0]     rem_nx;
    logic [CNT_W-1:0]          cnt_q;
    logic                      q_bit;
    logic                      accept;
    logic                      last;
    logic [DIVIDEND_WIDTH-1:0] q_raw;
    logic [DIVIDEND_WIDTH-1:0] q_fin;

    assign ready_o = state_q == IDLE;
    assign accept  = ready_o && valid_i;
    assign last    = cnt_q == CNT_W'(DIVIDEND_WIDTH - 1);

    div_restoring_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i    (rem_q),
        .bit_i    (dvd_q[DIVIDEND_WIDTH-1]),
        .divisor_i(dsr_q),
        .rem_o    (rem_nx),
        .q_o      (q_bit)
    );

    // dividend bits shift out of the top while quotient bits shift in at the bottom
    assign q_raw = {dvd_q[DIVIDEND_WIDTH-2:0], q_bit};

`ifdef DIV_ROUND_NEAREST_EN
    assign q_fin = ({rem_nx, 1'b0} >= {1'b0, dsr_q}) ? q_raw + DIVIDEND_WIDTH'(1) : q_raw;
`else
    assign q_fin = q_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)                        state_d = (divisor_i == '0) ? DONE : CALC;
        else if (state_q == CALC && last)  state_d = DONE;
        else if (state_q == DONE)          state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q         <= '0;
            dsr_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            valid_o       <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            // the strobe trails the DONE state by one edge
            valid_o <= state_q == DONE;
            if (accept) begin
                dvd_q <= dividend_i;
                dsr_q <= divisor_i;
                rem_q <= '0;
                cnt_q <= '0;
                if (divisor_i == '0) begin
                    quotient_o    <= '1;
                    remainder_o   <= '0;
                    div_by_zero_o <= 1'b1;
                end
            end else if (state_q == CALC) begin
                dvd_q <= q_raw;
                rem_q <= rem_nx;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last) begin
                    quotient_o    <= q_fin;
                    remainder_o   <= rem_nx;
                    div_by_zero_o <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [23:0] dividend_i;
    logic [11:0] divisor_i;
    logic        valid_o;
    logic [23:0] quotient_o;
    logic [11:0] remainder_o;
    logic        div_by_zero_o;
    int          total = 0;
    int          bad = 0;
    int          lat;
    int          stray;

    seq_divider dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .valid_o      (valid_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // accept one op, then count edges until valid_o; optionally pulse a second request mid-CALC
    task automatic do_op(input logic [23:0] a, input logic [11:0] b, input bit inj, output int l);
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        valid_i    = 1'b1;
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        dividend_i = 24'($urandom);
        divisor_i  = 12'($urandom);
        l = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                l = n;
                break;
            end
            if (inj && n == 5) begin
                chk("busy_ready", {31'b0, ready_o}, 32'd0);
                dividend_i = 24'd100;
                divisor_i  = 12'd3;
                valid_i    = 1'b1;
            end
            if (inj && n == 6) valid_i = 1'b0;
        end
    endtask

    task automatic chk_res(input string tag, input int l, input int el, input logic [23:0] q,
                           input logic [11:0] r, input logic z);
        chk({tag, "_lat"}, l, el);
        chk({tag, "_q"}, {8'b0, quotient_o}, {8'b0, q});
        chk({tag, "_r"}, {20'b0, remainder_o}, {20'b0, r});
        chk({tag, "_dbz"}, {31'b0, div_by_zero_o}, {31'b0, z});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'b0, valid_o}, 32'd0);
        chk({tag, "_hold"}, {8'b0, quotient_o}, {8'b0, q});
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_q", {8'b0, quotient_o}, 32'd0);
        chk("rst_r", {20'b0, remainder_o}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef DIV_ROUND_NEAREST_EN
        do_op(24'd1000, 12'd7, 1'b0, lat);  chk_res("d1000_7", lat, 25, 24'd143, 12'd6, 1'b0);
`else
        do_op(24'd1000, 12'd7, 1'b0, lat);  chk_res("d1000_7", lat, 25, 24'd142, 12'd6, 1'b0);
`endif
        do_op(24'hFFFFFF, 12'h001, 1'b0, lat); chk_res("max_1", lat, 25, 24'hFFFFFF, 12'd0, 1'b0);
        do_op(24'hFFFFFF, 12'hFFF, 1'b0, lat); chk_res("max_fff", lat, 25, 24'h001001, 12'd0, 1'b0);
        do_op(24'd0, 12'd5, 1'b0, lat);        chk_res("zero_5", lat, 25, 24'd0, 12'd0, 1'b0);
        do_op(24'd5, 12'd0, 1'b0, lat);        chk_res("dbz", lat, 1, 24'hFFFFFF, 12'd0, 1'b1);
`ifdef DIV_ROUND_NEAREST_EN
        do_op(24'd10, 12'd4, 1'b0, lat);       chk_res("d10_4", lat, 25, 24'd3, 12'd2, 1'b0);
        do_op(24'hFFFFFF, 12'd2, 1'b0, lat);   chk_res("max_2", lat, 25, 24'h800000, 12'd1, 1'b0);
        do_op(24'd1000, 12'd7, 1'b1, lat);     chk_res("busy", lat, 25, 24'd143, 12'd6, 1'b0);
`else
        do_op(24'd10, 12'd4, 1'b0, lat);       chk_res("d10_4", lat, 25, 24'd2, 12'd2, 1'b0);
        do_op(24'hFFFFFF, 12'd2, 1'b0, lat);   chk_res("max_2", lat, 25, 24'h7FFFFF, 12'd1, 1'b0);
        do_op(24'd1000, 12'd7, 1'b1, lat);     chk_res("busy", lat, 25, 24'd142, 12'd6, 1'b0);
`endif
        do_op(24'd9, 12'd4, 1'b0, lat);        chk_res("d9_4", lat, 25, 24'd2, 12'd1, 1'b0);

        // the ignored 100/3 must never produce a second strobe
        stray = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (valid_o) stray++;
        end
        chk("no_stray", stray, 0);

        // reset at CALC step 10 of 1000/7 after a nonzero result is held
        do_op(24'd1000, 12'd7, 1'b0, lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend_i = 24'd1000;
        divisor_i  = 12'd7;
        valid_i    = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, ready_o}, 32'd1);
        chk("mid_rst_q", {8'b0, quotient_o}, 32'd0);
        chk("mid_rst_r", {20'b0, remainder_o}, 32'd0);
        chk("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (valid_o) stray++;
        end
        chk("mid_rst_nostrobe", stray, 0);
        do_op(24'd9, 12'd3, 1'b0, lat);        chk_res("d9_3", lat, 25, 24'd3, 12'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
